// File: rtl/matmul_engine.sv
// Sequential N x N matrix multiplier: one multiply-accumulate per cycle against
// external single-cycle-latency A/B/C memories, with optional C accumulation.
module matmul_engine #(
  parameter int DW     = 8,
  parameter int N      = 64,
  parameter int SIGNED = 0,
  localparam int KW    = $clog2(N),
  localparam int AW    = 2 * KW,
  localparam int CW    = 2 * DW + KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          accum,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_rdata,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_rdata,
  output logic [AW-1:0] c_raddr,
  input  logic [CW-1:0] c_rdata,
  output logic [AW-1:0] c_waddr,
  output logic [CW-1:0] c_wdata,
  output logic          c_we
);

  typedef enum logic [2:0] {IDLE, RUN, LAST, WRITE, DONE} state_t;

  localparam logic [KW-1:0] LAST_IDX = KW'(N - 1);

  state_t          state;
  logic [KW-1:0]   i, j, k;
  logic [CW-1:0]   acc;
  logic            accum_lat;
  logic            mac_en, mac_first;
  logic            we_q;

  logic [2*DW-1:0] a_ext, b_ext, prod;
  logic [CW-1:0]   prod_ext, seed, sum;
  logic [KW-1:0]   k_inc, j_inc, i_next;

  // Operands are widened to 2*DW before multiplying, so the truncated
  // product is the exact signed or unsigned result.
  assign a_ext    = (SIGNED != 0) ? {{DW{a_rdata[DW-1]}}, a_rdata} : {{DW{1'b0}}, a_rdata};
  assign b_ext    = (SIGNED != 0) ? {{DW{b_rdata[DW-1]}}, b_rdata} : {{DW{1'b0}}, b_rdata};
  assign prod     = a_ext * b_ext;
  assign prod_ext = (SIGNED != 0) ? {{KW{prod[2*DW-1]}}, prod} : {{KW{1'b0}}, prod};
  assign seed     = accum_lat ? c_rdata : '0;
  assign sum      = (mac_first ? seed : acc) + prod_ext;

  assign k_inc  = k + 1'b1;
  assign j_inc  = j + 1'b1;
  assign i_next = (j == LAST_IDX) ? i + 1'b1 : i;

  // The write strobe is gated so an abort or reset landing in WRITE
  // suppresses the pending write in that very cycle.
  assign c_we = we_q & ~abort & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      we_q      <= 1'b0;
      a_addr    <= '0;
      b_addr    <= '0;
      c_raddr   <= '0;
      c_waddr   <= '0;
      c_wdata   <= '0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      accum_lat <= 1'b0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
    end else if (abort && (state inside {RUN, LAST, WRITE})) begin
      state   <= IDLE;
      busy    <= 1'b0;
      we_q    <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      c_raddr <= '0;
      c_waddr <= '0;
      c_wdata <= '0;
      mac_en  <= 1'b0;
    end else begin
      mac_en <= 1'b0;
      done   <= 1'b0;
      if (mac_en) acc <= sum;
      case (state)
        IDLE: begin
          if (start && !abort && !done) begin
            state     <= RUN;
            busy      <= 1'b1;
            accum_lat <= accum;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            a_addr    <= '0;
            b_addr    <= '0;
            c_raddr   <= '0;
          end
        end
        RUN: begin
          mac_en    <= 1'b1;
          mac_first <= (k == '0);
          c_raddr   <= '0;
          if (k == LAST_IDX) begin
            state  <= LAST;
            a_addr <= '0;
            b_addr <= '0;
          end else begin
            k      <= k_inc;
            a_addr <= {i, k_inc};
            b_addr <= {k_inc, j};
          end
        end
        LAST: begin
          state   <= WRITE;
          we_q    <= 1'b1;
          c_waddr <= {i, j};
          c_wdata <= sum;
        end
        WRITE: begin
          we_q    <= 1'b0;
          c_waddr <= '0;
          c_wdata <= '0;
          j       <= j_inc;
          i       <= i_next;
          k       <= '0;
          if (i == LAST_IDX && j == LAST_IDX) begin
            state <= DONE;
          end else begin
            state   <= RUN;
            a_addr  <= {i_next, {KW{1'b0}}};
            b_addr  <= {{KW{1'b0}}, j_inc};
            c_raddr <= {i_next, j_inc};
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          we_q    <= 1'b0;
          a_addr  <= '0;
          b_addr  <= '0;
          c_raddr <= '0;
          c_waddr <= '0;
          c_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 Parameter DW, default 8: element width of A and B.
REQ-002 Parameter N, default 64: square matrix dimension, power of two, 2..256.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands and result.
REQ-004 Derived localparams SHALL be KW = log2(N), AW = 2*KW and CW = 2*DW+KW; defaults give 22-bit C over 4096 words.
REQ-005 The block SHALL be reset synchronously and active-high; the ports are clk and rst.
REQ-006 Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- accum  in  1  mode, latched with start: 0 = C=A*B, 1 = C=C+A*B.
- abort  in  1  cancels the current job.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- a_addr  out  AW  A read address, row-major (i*N+k).
- a_rdata  in  DW  A read data, valid 1 cycle after a_addr.
- b_addr  out  AW  B read address (k*N+j).
- b_rdata  in  DW  B read data, 1-cycle latency.
- c_raddr  out  AW  C read address, used in accum mode.
- c_rdata  in  CW  C read data, 1-cycle latency.
- c_waddr  out  AW  C write address (i*N+j).
- c_wdata  out  CW  C write data.
- c_we  out  1  C write strobe, one cycle per element.

Function
REQ-007 The state machine SHALL have the states IDLE, RUN, LAST, WRITE and DONE; any other encoding SHALL go to IDLE.
REQ-008 IDLE: start=1 SHALL latch accum, clear i, j and k, and move to RUN on the next edge; start outside IDLE SHALL be ignored.
REQ-009 RUN SHALL last N cycles per element; in cycle k it SHALL drive a_addr=i*N+k and b_addr=k*N+j, then move to LAST after k=N-1.
REQ-010 In the first RUN cycle of each element, c_raddr SHALL equal i*N+j; c_raddr SHALL hold 0 otherwise.
REQ-011 Accumulator, on the cycle after each RUN cycle:
- for k=0: acc <= seed + a*b, where seed = c_rdata if accum is latched, else 0;
- for k>0: acc <= acc + a*b.
REQ-012 The product SHALL be 2*DW bits, sign-extended if SIGNED=1, otherwise zero-extended, to CW bits; the sum SHALL wrap modulo 2^CW.
REQ-013 LAST SHALL add the final product; WRITE SHALL assert c_we=1 for exactly one cycle, with c_waddr=i*N+j and c_wdata=acc.
REQ-014 After WRITE, j SHALL increment; at the wrap j=N-1 -> 0, i SHALL increment.
REQ-015 After the WRITE of element (N-1,N-1), the state SHALL move to DONE; otherwise it SHALL return to RUN with k=0.
REQ-016 DONE SHALL assert done=1 for one cycle and then return to IDLE; done and start SHALL never be high in the same accepted cycle.
REQ-017 Latency: done SHALL be high exactly N*N*(N+2)+1 cycles after the edge that samples start (270337 cycles at the defaults).
REQ-018 Overwrite mode SHALL never overflow, because CW covers N maximum products.
REQ-019 abort=1 in RUN, LAST or WRITE SHALL force IDLE on the next edge.
REQ-020 In that abort case, no c_we SHALL be issued in the abort cycle or later, and no done SHALL be issued.
REQ-021 abort in IDLE or DONE SHALL have no effect; abort and start together in IDLE SHALL give abort priority.
REQ-022 Outside RUN, all addresses SHALL be 0; c_we SHALL be 0 outside WRITE.

Reset
REQ-023 rst=1 SHALL force, on the next edge: state=IDLE; busy, done and c_we = 0; all addresses, c_wdata, acc, i, j, k and the latched accum = 0.
REQ-024 rst SHALL take priority over start and abort.
REQ-025 rst asserted mid-job SHALL stop all memory activity on the following cycle, and no partial write SHALL complete.

Verification
REQ-026 N=4, DW=8, A=identity, B[r][c]=r*4+c, accum=0 -> C equals B; 16 c_we pulses; done exactly 97 cycles after start.
REQ-027 N=4, all A and B = 255, unsigned -> every C word = 4*65025 = 260100 (CW=18, no overflow).
REQ-028 N=4, SIGNED=1, A all -128, B all 127 -> every C word = -65024, 18-bit two's complement.
REQ-029 accum=1, C preloaded with 5, A=B=identity -> diagonal 6, off-diagonal 5; a second accum run gives diagonal 7.
REQ-030 Abort in the RUN cycle of element 5 -> no further c_we, no done, busy=0 next cycle, C words 0..4 written and 5..15 untouched; a new start then completes normally.
REQ-031 Defaults (N=64, DW=8): random 8-bit vectors -> all 4096 words match the golden model and error count = 0; start pulsed while busy is ignored.
